// File: rtl/tpu_buffer_bank_pkg.sv
// Shared constants and types for the TPU buffer bank.
package tpu_buffer_bank_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int WORD_WIDTH = 160;
  localparam int MEM_AW     = 8;
  localparam int LANES      = 10;
  localparam int LANE_W     = 16;

  // Host bank-select encodings; the fourth code is rejected with an error response.
  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_P   = 2'd2;
  localparam logic [1:0] SEL_ERR = 2'd3;

  // Host port state: one outstanding request at a time.
  typedef enum logic {
    HOST_IDLE = 1'b0,
    HOST_RESP = 1'b1
  } host_state_e;

endpackage

// File: rtl/tpu_buffer_bank_ram.sv
// Single-port synchronous read-first RAM, shaped for block-RAM inference.
module tpu_bank_ram #(
  parameter int AW = 8,
  parameter int DW = 160
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // One access per edge; a write also returns the word it overwrites.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        r_mem[addr_i] <= wdata_i;
      end
      r_rdata <= r_mem[addr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/tpu_buffer_bank.sv
// Three single-ported buffer banks (A, B, P) shared between the TPU core and a
// lower-priority host request/response port.
//
// Host handshake: a request transfers on an edge where host_req_valid_i and
// host_req_ready_o are both high; the request fields must stay stable while
// valid is held. A response transfers on an edge where host_rsp_valid_o and
// host_rsp_ready_i are both high; response fields are stable until then.
// host_req_ready_o depends only on state, host_sel_i and the TPU enables.
module tpu_buffer_bank
  import tpu_buffer_bank_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ena_i,
  input  logic                  wea_i,
  input  logic [ADDR_WIDTH-1:0] addra_i,
  output logic [WORD_WIDTH-1:0] worda_o,
  input  logic                  enb_i,
  input  logic                  web_i,
  input  logic [ADDR_WIDTH-1:0] addrb_i,
  output logic [WORD_WIDTH-1:0] wordb_o,
  input  logic                  enp_i,
  input  logic                  wep_i,
  input  logic [ADDR_WIDTH-1:0] addrp_i,
  input  logic [WORD_WIDTH-1:0] wordp_i,
  input  logic                  host_req_valid_i,
  output logic                  host_req_ready_o,
  input  logic                  host_we_i,
  input  logic [1:0]            host_sel_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [WORD_WIDTH-1:0] host_wdata_i,
  output logic                  host_rsp_valid_o,
  input  logic                  host_rsp_ready_i,
  output logic [WORD_WIDTH-1:0] host_rdata_o,
  output logic                  host_err_o
);

  host_state_e r_state;
  host_state_e w_next_state;

  logic w_tpu_busy;
  logic w_host_fire;
  logic w_host_a, w_host_b, w_host_p;

  logic                  w_a_en, w_a_we, w_b_en, w_b_we, w_p_en, w_p_we;
  logic [MEM_AW-1:0]     w_a_addr, w_b_addr, w_p_addr;
  logic [WORD_WIDTH-1:0] w_a_wdata, w_b_wdata, w_p_wdata;
  logic [WORD_WIDTH-1:0] w_a_dout, w_b_dout, w_p_dout;
  logic [WORD_WIDTH-1:0] w_host_dout;

  logic                  r_a_rd_pend, r_b_rd_pend;
  logic [WORD_WIDTH-1:0] r_worda_hold, r_wordb_hold;
  logic                  r_rsp_rd_pend;
  logic [1:0]            r_rsp_sel;
  logic [WORD_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  // Address bits above the bank index alias and are deliberately ignored.
  logic w_unused;
  assign w_unused = ^{addra_i[ADDR_WIDTH-1:MEM_AW], addrb_i[ADDR_WIDTH-1:MEM_AW],
                      addrp_i[ADDR_WIDTH-1:MEM_AW], host_addr_i[ADDR_WIDTH-1:MEM_AW]};

  // The host is held off whenever the TPU claims the bank it is asking for.
  always_comb begin
    w_tpu_busy = 1'b0;
    case (host_sel_i)
      SEL_A:   w_tpu_busy = ena_i;
      SEL_B:   w_tpu_busy = enb_i;
      SEL_P:   w_tpu_busy = enp_i;
      default: w_tpu_busy = 1'b0;
    endcase
  end

  // Host FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= HOST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Host FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      HOST_IDLE: if (w_host_fire)      w_next_state = HOST_RESP;
      HOST_RESP: if (host_rsp_ready_i) w_next_state = HOST_IDLE;
      default:                         w_next_state = HOST_IDLE;
    endcase
  end

  // Host FSM outputs.
  always_comb begin
    host_req_ready_o = 1'b0;
    host_rsp_valid_o = 1'b0;
    case (r_state)
      HOST_IDLE: host_req_ready_o = !w_tpu_busy;
      HOST_RESP: host_rsp_valid_o = 1'b1;
      default: begin
        host_req_ready_o = 1'b0;
        host_rsp_valid_o = 1'b0;
      end
    endcase
  end

  assign w_host_fire = host_req_valid_i && host_req_ready_o;
  assign w_host_a    = w_host_fire && (host_sel_i == SEL_A);
  assign w_host_b    = w_host_fire && (host_sel_i == SEL_B);
  assign w_host_p    = w_host_fire && (host_sel_i == SEL_P);

  // Per-bank port muxes; the TPU always wins. TPU writes to A/B carry zero data.
  assign w_a_en    = ena_i || w_host_a;
  assign w_a_we    = ena_i ? wea_i : host_we_i;
  assign w_a_addr  = ena_i ? addra_i[MEM_AW-1:0] : host_addr_i[MEM_AW-1:0];
  assign w_a_wdata = ena_i ? '0 : host_wdata_i;

  assign w_b_en    = enb_i || w_host_b;
  assign w_b_we    = enb_i ? web_i : host_we_i;
  assign w_b_addr  = enb_i ? addrb_i[MEM_AW-1:0] : host_addr_i[MEM_AW-1:0];
  assign w_b_wdata = enb_i ? '0 : host_wdata_i;

  assign w_p_en    = enp_i || w_host_p;
  assign w_p_we    = enp_i ? wep_i : host_we_i;
  assign w_p_addr  = enp_i ? addrp_i[MEM_AW-1:0] : host_addr_i[MEM_AW-1:0];
  assign w_p_wdata = enp_i ? wordp_i : host_wdata_i;

  tpu_bank_ram #(.AW(MEM_AW), .DW(WORD_WIDTH)) u_bank_a (
    .clk_i(clk_i), .en_i(w_a_en), .we_i(w_a_we), .addr_i(w_a_addr),
    .wdata_i(w_a_wdata), .rdata_o(w_a_dout)
  );

  tpu_bank_ram #(.AW(MEM_AW), .DW(WORD_WIDTH)) u_bank_b (
    .clk_i(clk_i), .en_i(w_b_en), .we_i(w_b_we), .addr_i(w_b_addr),
    .wdata_i(w_b_wdata), .rdata_o(w_b_dout)
  );

  tpu_bank_ram #(.AW(MEM_AW), .DW(WORD_WIDTH)) u_bank_p (
    .clk_i(clk_i), .en_i(w_p_en), .we_i(w_p_we), .addr_i(w_p_addr),
    .wdata_i(w_p_wdata), .rdata_o(w_p_dout)
  );

  // Bank whose output carries the host read data, chosen at acceptance.
  always_comb begin
    w_host_dout = '0;
    case (r_rsp_sel)
      SEL_A:   w_host_dout = w_a_dout;
      SEL_B:   w_host_dout = w_b_dout;
      SEL_P:   w_host_dout = w_p_dout;
      default: w_host_dout = '0;
    endcase
  end

  // Capture RAM outputs one cycle after they appear so later accesses by the
  // other requester cannot disturb TPU words or a pending host response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a_rd_pend   <= 1'b0;
      r_b_rd_pend   <= 1'b0;
      r_worda_hold  <= '0;
      r_wordb_hold  <= '0;
      r_rsp_rd_pend <= 1'b0;
      r_rsp_sel     <= SEL_A;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_a_rd_pend   <= ena_i && !wea_i;
      r_b_rd_pend   <= enb_i && !web_i;
      r_rsp_rd_pend <= 1'b0;
      if (r_a_rd_pend) begin
        r_worda_hold <= w_a_dout;
      end
      if (r_b_rd_pend) begin
        r_wordb_hold <= w_b_dout;
      end
      if (r_rsp_rd_pend) begin
        r_rsp_rdata <= w_host_dout;
      end
      if (w_host_fire) begin
        r_rsp_sel     <= host_sel_i;
        r_rsp_rd_pend <= !host_we_i && (host_sel_i != SEL_ERR);
        r_rsp_rdata   <= '0;
        r_rsp_err     <= (host_sel_i == SEL_ERR);
      end
    end
  end

  assign worda_o      = r_a_rd_pend   ? w_a_dout    : r_worda_hold;
  assign wordb_o      = r_b_rd_pend   ? w_b_dout    : r_wordb_hold;
  assign host_rdata_o = r_rsp_rd_pend ? w_host_dout : r_rsp_rdata;
  assign host_err_o   = r_rsp_err;

endmodule

// File: tb/tb_tpu_buffer_bank.sv
// Directed and randomized bench for tpu_buffer_bank with an array-based memory model.
module tb_tpu_buffer_bank;
  import tpu_buffer_bank_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  ena_i = 1'b0, wea_i = 1'b0;
  logic [ADDR_WIDTH-1:0] addra_i = '0;
  logic [WORD_WIDTH-1:0] worda_o;
  logic                  enb_i = 1'b0, web_i = 1'b0;
  logic [ADDR_WIDTH-1:0] addrb_i = '0;
  logic [WORD_WIDTH-1:0] wordb_o;
  logic                  enp_i = 1'b0, wep_i = 1'b0;
  logic [ADDR_WIDTH-1:0] addrp_i = '0;
  logic [WORD_WIDTH-1:0] wordp_i = '0;
  logic                  host_req_valid_i = 1'b0;
  logic                  host_req_ready_o;
  logic                  host_we_i = 1'b0;
  logic [1:0]            host_sel_i = 2'd0;
  logic [ADDR_WIDTH-1:0] host_addr_i = '0;
  logic [WORD_WIDTH-1:0] host_wdata_i = '0;
  logic                  host_rsp_valid_o;
  logic                  host_rsp_ready_i = 1'b0;
  logic [WORD_WIDTH-1:0] host_rdata_o;
  logic                  host_err_o;

  // Reference model: plain arrays indexed by address modulo the bank depth.
  logic [WORD_WIDTH-1:0] m_a [256];
  logic [WORD_WIDTH-1:0] m_b [256];
  logic [WORD_WIDTH-1:0] m_p [256];
  logic [WORD_WIDTH-1:0] exp_worda = '0;
  logic [WORD_WIDTH-1:0] exp_wordb = '0;

  int n_checks = 0;
  int n_errors = 0;

  tpu_buffer_bank dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ena_i(ena_i), .wea_i(wea_i), .addra_i(addra_i), .worda_o(worda_o),
    .enb_i(enb_i), .web_i(web_i), .addrb_i(addrb_i), .wordb_o(wordb_o),
    .enp_i(enp_i), .wep_i(wep_i), .addrp_i(addrp_i), .wordp_i(wordp_i),
    .host_req_valid_i(host_req_valid_i), .host_req_ready_o(host_req_ready_o),
    .host_we_i(host_we_i), .host_sel_i(host_sel_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_rsp_valid_o(host_rsp_valid_o),
    .host_rsp_ready_i(host_rsp_ready_i), .host_rdata_o(host_rdata_o),
    .host_err_o(host_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [WORD_WIDTH-1:0] obs,
                       input logic [WORD_WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_WIDTH-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [WORD_WIDTH-1:0] lane_word(input int mul);
    logic [WORD_WIDTH-1:0] w;
    w = '0;
    for (int j = 0; j < LANES; j++) w[j*LANE_W +: LANE_W] = 16'(mul * (j + 1));
    return w;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request and wait (bounded) until it is accepted; returns just after the accepting edge.
  task automatic host_accept(input logic we, input logic [1:0] sel,
                             input logic [ADDR_WIDTH-1:0] addr, input logic [WORD_WIDTH-1:0] wd);
    int waits;
    waits = 0;
    host_req_valid_i = 1'b1;
    host_we_i = we;
    host_sel_i = sel;
    host_addr_i = addr;
    host_wdata_i = wd;
    #1;
    while (!host_req_ready_o && waits < 20) begin
      step();
      waits++;
    end
    check("req_ready_wait", {159'd0, host_req_ready_o}, 160'd1);
    step();
    host_req_valid_i = 1'b0;
    check("rsp_valid_latency", {159'd0, host_rsp_valid_o}, 160'd1);
    check("req_ready_in_resp", {159'd0, host_req_ready_o}, 160'd0);
  endtask

  task automatic host_finish();
    host_rsp_ready_i = 1'b1;
    step();
    host_rsp_ready_i = 1'b0;
    check("rsp_valid_cleared", {159'd0, host_rsp_valid_o}, 160'd0);
  endtask

  task automatic host_xfer(input logic we, input logic [1:0] sel, input logic [ADDR_WIDTH-1:0] addr,
                           input logic [WORD_WIDTH-1:0] wd, output logic [WORD_WIDTH-1:0] rd,
                           output logic err);
    host_accept(we, sel, addr, wd);
    rd = host_rdata_o;
    err = host_err_o;
    host_finish();
  endtask

  task automatic host_write(input logic [1:0] sel, input logic [ADDR_WIDTH-1:0] addr,
                            input logic [WORD_WIDTH-1:0] wd);
    logic [WORD_WIDTH-1:0] rd;
    logic err;
    host_xfer(1'b1, sel, addr, wd, rd, err);
    if (sel == SEL_A) m_a[addr[7:0]] = wd;
    if (sel == SEL_B) m_b[addr[7:0]] = wd;
    if (sel == SEL_P) m_p[addr[7:0]] = wd;
  endtask

  task automatic host_read_check(input string tag, input logic [1:0] sel,
                                 input logic [ADDR_WIDTH-1:0] addr);
    logic [WORD_WIDTH-1:0] rd;
    logic [WORD_WIDTH-1:0] exp;
    logic err;
    host_xfer(1'b0, sel, addr, '0, rd, err);
    exp = (sel == SEL_A) ? m_a[addr[7:0]] : (sel == SEL_B) ? m_b[addr[7:0]] : m_p[addr[7:0]];
    check(tag, rd, exp);
    check({tag, "_err"}, {159'd0, err}, 160'd0);
  endtask

  task automatic tpu_read_a(input logic [ADDR_WIDTH-1:0] addr);
    ena_i = 1'b1; wea_i = 1'b0; addra_i = addr;
    step();
    ena_i = 1'b0;
    exp_worda = m_a[addr[7:0]];
    check("tpu_read_a", worda_o, exp_worda);
  endtask

  task automatic tpu_read_b(input logic [ADDR_WIDTH-1:0] addr);
    enb_i = 1'b1; web_i = 1'b0; addrb_i = addr;
    step();
    enb_i = 1'b0;
    exp_wordb = m_b[addr[7:0]];
    check("tpu_read_b", wordb_o, exp_wordb);
  endtask

  task automatic tpu_write_p(input logic [ADDR_WIDTH-1:0] addr, input logic [WORD_WIDTH-1:0] wd);
    enp_i = 1'b1; wep_i = 1'b1; addrp_i = addr; wordp_i = wd;
    step();
    enp_i = 1'b0; wep_i = 1'b0;
    m_p[addr[7:0]] = wd;
  endtask

  initial begin
    logic [WORD_WIDTH-1:0] rd;
    logic err;
    logic [ADDR_WIDTH-1:0] ra;

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_worda", worda_o, '0);
    check("rst_wordb", wordb_o, '0);
    check("rst_rsp_valid", {159'd0, host_rsp_valid_o}, '0);
    check("rst_rdata", host_rdata_o, '0);
    check("rst_err", {159'd0, host_err_o}, '0);
    rst_i = 1'b0;
    step();
    check("idle_ready", {159'd0, host_req_ready_o}, 160'd1);

    // Fill every bank with random words so any address has a known value.
    for (int i = 0; i < 256; i++) begin
      host_write(SEL_A, ADDR_WIDTH'(i), rand_word());
      host_write(SEL_B, ADDR_WIDTH'(i), rand_word());
      host_write(SEL_P, ADDR_WIDTH'(i), rand_word());
    end

    // Host write then read of A[3], lane0 = 9; write response carries zero data.
    host_xfer(1'b1, SEL_A, 12'h003, 160'd9, rd, err);
    m_a[3] = 160'd9;
    check("wr_rsp_rdata", rd, '0);
    check("wr_rsp_err", {159'd0, err}, '0);
    host_read_check("rd_a3", SEL_A, 12'h003);

    // Preload A[0..9] with lane j = (i+1)(j+1); TPU reads index 5.
    for (int i = 0; i < 10; i++) host_write(SEL_A, ADDR_WIDTH'(i), lane_word(i + 1));
    tpu_read_a(12'h005);
    check("worda_lane2", {144'd0, worda_o[47:32]}, 160'd18);
    step();
    check("worda_hold1", worda_o, exp_worda);
    host_read_check("rd_a7_during_hold", SEL_A, 12'h007);
    check("worda_hold_after_host", worda_o, exp_worda);

    // TPU write of P at an address that aliases index 0.
    tpu_write_p(12'h200, lane_word(2));
    step();
    host_read_check("rd_p200", SEL_P, 12'h200);
    host_read_check("rd_p000_alias", SEL_P, 12'h000);

    // TPU write to A stores zero.
    ena_i = 1'b1; wea_i = 1'b1; addra_i = 12'h00F;
    step();
    ena_i = 1'b0; wea_i = 1'b0;
    m_a[15] = '0;
    check("worda_unchanged_by_write", worda_o, exp_worda);
    host_read_check("rd_a15_zero", SEL_A, 12'h00F);

    // Host read of B stalled by three cycles of TPU B reads.
    enb_i = 1'b1; web_i = 1'b0; addrb_i = 12'h107;
    host_req_valid_i = 1'b1; host_we_i = 1'b0; host_sel_i = SEL_B; host_addr_i = 12'h004;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_ready", {159'd0, host_req_ready_o}, 160'd0);
      step();
    end
    enb_i = 1'b0;
    exp_wordb = m_b[7];
    #1;
    check("stall_release_ready", {159'd0, host_req_ready_o}, 160'd1);
    check("stall_wordb", wordb_o, exp_wordb);
    step();
    host_req_valid_i = 1'b0;
    check("stall_rsp_valid", {159'd0, host_rsp_valid_o}, 160'd1);
    check("stall_rdata", host_rdata_o, m_b[4]);
    host_finish();

    // Response back-pressure while the TPU hammers the same bank.
    host_accept(1'b0, SEL_A, 12'h105, '0);
    host_req_valid_i = 1'b1; host_we_i = 1'b0; host_sel_i = SEL_ERR;
    ena_i = 1'b1; wea_i = 1'b0; addra_i = 12'h009;
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", {159'd0, host_rsp_valid_o}, 160'd1);
      check("bp_rdata", host_rdata_o, m_a[5]);
      check("bp_req_ready", {159'd0, host_req_ready_o}, 160'd0);
      step();
    end
    ena_i = 1'b0;
    host_req_valid_i = 1'b0;
    exp_worda = m_a[9];
    check("bp_worda", worda_o, exp_worda);
    host_finish();

    // Illegal select.
    host_xfer(1'b0, SEL_ERR, 12'h001, '0, rd, err);
    check("illegal_err", {159'd0, err}, 160'd1);
    check("illegal_rdata", rd, '0);
    host_read_check("err_cleared", SEL_B, 12'h010);

    // Randomized mix of host and TPU traffic.
    for (int it = 0; it < 200; it++) begin
      ra = ADDR_WIDTH'($urandom_range(0, 4095));
      case ($urandom_range(0, 7))
        0: host_write(SEL_A, ra, rand_word());
        1: host_write(SEL_B, ra, rand_word());
        2: host_read_check("rnd_rd_a", SEL_A, ra);
        3: host_read_check("rnd_rd_b", SEL_B, ra);
        4: host_read_check("rnd_rd_p", SEL_P, ra);
        5: tpu_read_a(ra);
        6: tpu_read_b(ra);
        default: tpu_write_p(ra, rand_word());
      endcase
      check("rnd_worda_hold", worda_o, exp_worda);
      check("rnd_wordb_hold", wordb_o, exp_wordb);
    end

    // Asynchronous reset in the middle of a response.
    host_accept(1'b0, SEL_A, 12'h003, '0);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_rsp_valid", {159'd0, host_rsp_valid_o}, '0);
    check("mid_rst_rdata", host_rdata_o, '0);
    check("mid_rst_worda", worda_o, '0);
    check("mid_rst_wordb", wordb_o, '0);
    exp_worda = '0;
    exp_wordb = '0;
    #2;
    rst_i = 1'b0;
    step();
    check("post_rst_ready", {159'd0, host_req_ready_o}, 160'd1);
    check("post_rst_rsp_valid", {159'd0, host_rsp_valid_o}, '0);
    host_read_check("post_rst_rd_a3", SEL_A, 12'h003);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tpu_buffer_bank.md
Name: tpu_buffer_bank

Overview:
- Memory-side responder for the TPU's three buffer interfaces: A and B are read (and optionally written), P is written.
- Holds three single-ported banks, A, B and P.
- Serves TPU accesses with fixed one-cycle read latency.
- Gives the host a request/response port to preload A/B and read back P. The host port is arbitrated below TPU priority.
- Sits between the tpu core and the PS/host interconnect on the PYNQ-Z2 fabric.

Parameters:
- ADDR_WIDTH, 12: width of all address ports (`ADDR_WIDTH).
- WORD_WIDTH, 160: buffer word width, 10 lanes x 16 bit (`WORD_WIDTH).
- MEM_AW, 8: bank index width. Each bank has 2^MEM_AW words, indexed by addr[MEM_AW-1:0]; upper address bits are ignored.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ena_i  in  1  TPU bank-A enable
- wea_i  in  1  TPU bank-A write enable
- addra_i  in  ADDR_WIDTH  TPU bank-A address
- worda_o  out  WORD_WIDTH  bank-A read data
- enb_i  in  1  TPU bank-B enable
- web_i  in  1  TPU bank-B write enable
- addrb_i  in  ADDR_WIDTH  TPU bank-B address
- wordb_o  out  WORD_WIDTH  bank-B read data
- enp_i  in  1  TPU bank-P enable
- wep_i  in  1  TPU bank-P write enable
- addrp_i  in  ADDR_WIDTH  TPU bank-P address
- wordp_i  in  WORD_WIDTH  bank-P write data
- host_req_valid_i  in  1  host request valid
- host_req_ready_o  out  1  host request accepted when valid&ready
- host_we_i  in  1  1 = write, 0 = read
- host_sel_i  in  2  bank select: 0 = A, 1 = B, 2 = P, 3 = illegal
- host_addr_i  in  ADDR_WIDTH  host address
- host_wdata_i  in  WORD_WIDTH  host write data
- host_rsp_valid_o  out  1  response valid
- host_rsp_ready_i  in  1  host accepts response
- host_rdata_o  out  WORD_WIDTH  read data; 0 for writes and errors
- host_err_o  out  1  response flags an illegal select

Behaviour:
- Reset (rst_i high, async):
  - worda_o, wordb_o, host_rsp_valid_o, host_err_o and host_rdata_o clear to 0.
  - The host FSM returns to IDLE and any pending response is dropped.
  - Bank contents are not reset.
- TPU A/B read:
  - en&&!we sampled at edge N; data appears on word*_o after edge N, stable through cycle N+1.
  - word*_o holds its last value until the next TPU read on that bank; host reads do not disturb it.
- TPU write (A, B or P): en&&we writes at edge N. Port A/B write data is taken as 0; reserved, since the TPU never writes A/B.
- Read-first semantics: a read and a write to the same address at the same edge return the old data.
- Each bank performs exactly one access per edge. TPU access to a bank has absolute priority over host access.
- Host FSM states:
  - IDLE: host_req_ready_o = 1 unless the selected bank's TPU enable is high this cycle. This is a combinational stall: ready stays low until the bank is free, and valid must be held with the request stable.
  - On valid&&ready at edge N, go to RESP. The access is performed at edge N. host_rsp_valid_o = 1 from N+1.
  - Read responses give the bank word. Write responses give rdata = 0, err = 0.
  - host_sel_i = 3 is accepted with no bank access; the response has err = 1, rdata = 0.
  - RESP: host_req_ready_o = 0 (one outstanding request). Response outputs are held stable until host_rsp_ready_i.
  - RESP -> IDLE on host_rsp_ready_i. The next request is accepted at the earliest on the following cycle.
- Host read of P at the same edge as a TPU write of P: the host is stalled, so the write always lands first.
- Address wrap: an address >= 2^MEM_AW aliases modulo 2^MEM_AW. No error is raised for this.
- No combinational path from host_rsp_ready_i to host_req_ready_o.

Decomposition:
- def.v holds ADDR_WIDTH and WORD_WIDTH plus new bank-select constants: SEL_A = 2'd0, SEL_B = 2'd1, SEL_P = 2'd2.
- One sub-module, tpu_bank_ram: single port, synchronous read-first, depth 2^MEM_AW, BRAM-inferable. It is instantiated three times.
- A per-bank mux selects the TPU or host address/we/data.

Test Plan:
- Host writes A[0x003] = 0x...0009 (lane0 = 9), then reads it back -> rsp_valid one cycle after acceptance, rdata lane0 = 9, err = 0.
- Preload A[0..9] lane j = (i+1)(j+1). TPU pulses ena_i with addra_i = 0x005 at edge N -> worda_o lane2 = 18 after N; held while ena_i = 0.
- TPU writes P[0x200] = lane k = 2*(k+1) at edge N; host reads P addr 0x200 later -> rdata matches. Address 0x200 aliases to index 0x00 with MEM_AW = 8.
- Host read of B is requested while enb_i = 1 for 3 cycles -> host_req_ready_o = 0 for those 3 cycles, accepted on the 4th, correct data returned.
- Response back-pressure: host_rsp_ready_i = 0 for 5 cycles -> rsp_valid/rdata stable, req_ready = 0; request with host_sel_i = 3 -> err = 1, rdata = 0.
- Assert rst_i mid-RESP (asynchronous, between edges) -> rsp_valid drops immediately; after release req_ready = 1 and earlier-written A data is still readable.
